// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel divide value, square/strobe
// mode and enable, with a global phase restart. All outputs are registered.
module clk_div_multi #(
  parameter int              N_CH        = 4,
  parameter int              CNT_W       = 24,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(9_999_999),
  parameter int              CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  wr_hit;

  // Out-of-range channel indices match no channel, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_hit[i]) begin
        div_d[i]  = cfg_div;
        mode_d[i] = cfg_mode;
      end
      if (wr_hit[i] || sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i] = '0;
          if (mode_q[i]) begin
            clk_d[i]  = 1'b1;
            tick_d[i] = 1'b1;
          end else begin
            clk_d[i]  = ~clk_q[i];
            tick_d[i] = ~clk_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          if (mode_q[i]) clk_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= DEFAULT_DIV;
        cnt_q[i] <= '0;
      end
      mode_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider that generalises the single fixed-ratio LED blink divider. It produces N_CH independent divided outputs from the system clock (48 MHz HSOSC). Each channel has a runtime-writable divide value, a square-wave or strobe mode, a per-channel enable, and a global phase-sync. It sits between the oscillator and the display/LED/scan logic, which consume either `clk_out` levels or one-cycle `tick` strobes.

## Interface
Parameters:
- N_CH, 4, number of independent divider channels (1..16)
- CNT_W, 24, counter and divide-value width in bits
- DEFAULT_DIV, 9_999_999, reset divide value for every channel (48 MHz → 2.4 Hz square wave)
- CH_W, $clog2(N_CH) (min 1), channel index width (derived, not overridden)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- en  in  N_CH  per-channel enable; 0 freezes that channel's counter and output
- sync  in  1  one-cycle pulse; restarts phase of all channels
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel written by cfg_we
- cfg_div  in  CNT_W  new divide value D
- cfg_mode  in  1  new mode: 0 = square wave, 1 = strobe
- clk_out  out  N_CH  divided output per channel (registered)
- tick  out  N_CH  one-cycle strobe per channel, coincident with each rising edge of clk_out

## Operation
- Per-channel state: div[ch] (CNT_W), mode[ch], cnt[ch] (CNT_W), clk_out[ch], tick[ch].
- Reset (reset=0 at an edge): div=DEFAULT_DIV, mode=0, cnt=0, clk_out=0, tick=0 for all channels. Reset overrides all other inputs.
- Square mode, en[ch]=1: if cnt==div → cnt←0, clk_out toggles; else cnt←cnt+1. Half-period = D+1 cycles; period = 2(D+1). tick=1 for exactly the cycle in which clk_out has just gone 0→1.
- Strobe mode, en[ch]=1: if cnt==div → cnt←0, clk_out←1, tick←1; else cnt←cnt+1, clk_out←0, tick←0. Period D+1 cycles. D=0 gives clk_out and tick held at 1.
- en[ch]=0: cnt and clk_out hold; tick←0. Re-enable resumes from the held count with no extra cycle.
- cfg_we=1 with cfg_ch<N_CH: div[cfg_ch]←cfg_div, mode[cfg_ch]←cfg_mode, cnt←0, clk_out←0, tick←0 for that channel only. Other channels are unaffected.
- cfg_we with cfg_ch≥N_CH: ignored; no state changes.
- sync=1: cnt←0, clk_out←0, tick←0 on all channels. div and mode are kept.
- sync and cfg_we in the same cycle: both take effect. The written channel gets the new config; all channels restart from phase 0.
- cfg_we or sync takes priority over the normal count step in that cycle, regardless of en.
- Counter compare is equality only. Counters never exceed div, so no wrap past 2^CNT_W−1 is possible. Max D = 2^CNT_W−1.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Edge numbering: edge 1 is the first rising edge with reset=1 and en=1.
- Square mode: first clk_out 0→1 occurs at edge D+1. tick is high in the cycle after edge D+1 and low after edge D+2.
- Configuration latency: a write sampled at edge k is visible from edge k. Counting restarts at edge k+1, and the first toggle is at edge k+D+1.
- sync latency is identical to configuration latency.
- Reset asserted mid-period: outputs are 0 after the next edge. A new period starts per the first-toggle rule once reset releases.

## Test plan
- Reset/default: hold reset=0 for 3 cycles, all en=1, DEFAULT_DIV=3 override → clk_out=0 and tick=0 during reset. ch0 rises at edge 4, falls at edge 8, period 8. tick high 1 cycle per period.
- Per-channel config: write ch1 D=0 square, ch2 D=4 strobe, ch3 D=1 square → ch1 period 2, ch2 single-cycle pulse every 5 cycles, ch3 period 4. ch0 keeps its period with no glitch.
- Enable freeze: ch0 D=5, drop en[0] at cnt=3 for 10 cycles → clk_out[0] constant and tick[0]=0 throughout. After re-enable, the next toggle comes after exactly 3 more edges (cnt 3→4→5→toggle).
- Sync alignment: channels at D=2,3,5,7 running skewed; pulse sync → all clk_out=0. All rise together 3/4/6/8 edges later, and every LCM point sees all four ticks together.
- Collision/invalid: cfg_we to ch2 simultaneously with sync → ch2 uses new D and all channels restart. cfg_we with cfg_ch=N_CH (N_CH=3 build) → no channel changes.
- Mid-operation reset and max divide: assert reset=0 at cnt=2 of D=6 → outputs 0 next edge, and after release the first rise is at edge 7. CNT_W=4, D=15 → half-period exactly 16 cycles, with no overflow.
